// File: rtl/dpram_rd_streamer_pkg.sv
// Shared definitions for the dual-port RAM read streamer: FSM encoding and
// the elaboration-time check on FIFO sizing.
package dpram_rd_streamer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    FIN   = ST_FIN
  } state_e;

  // The FIFO must hold every in-flight read plus one word being popped,
  // and its pointers rely on natural power-of-two wrap.
  function automatic bit depthOk(input int depth, input int nDelay);
    return (depth >= nDelay + 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dpram_rd_streamer_fifo.sv
// First-word-fall-through FIFO: the head word is visible on o_popData
// whenever the FIFO is non-empty, and reads as zero when empty.
module sync_fifo_fwft #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_push,
  input  logic [DW-1:0]                 i_pushData,
  input  logic                          i_pop,
  output logic [DW-1:0]                 o_popData,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full    = (r_count == (PW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;
  assign o_popData = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_doPush) - (PW+1)'(w_doPop);
    end
  end

endmodule

// File: rtl/dpram_rd_streamer.sv
// Streams a programmed span of RAM words out as a valid/ready stream, using a
// tag pipe and credit check so RAM read latency never overflows the skid FIFO.
module dpram_rd_streamer
  import dpram_rd_streamer_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 14,
  parameter int N_DELAY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(FIFO_DEPTH + N_DELAY + 1) + 1;

  if (!depthOk(FIFO_DEPTH, N_DELAY)) begin : g_badDepth
    $error("FIFO_DEPTH must be a power of two and at least N_DELAY+2");
  end

  state_e           r_state;
  state_e           w_stateNext;
  logic [AW-1:0]    r_baseQ;
  logic [AW:0]      r_numQ;
  logic [AW:0]      r_rdCnt;
  logic [AW:0]      r_outCnt;
  logic [AW-1:0]    r_addrb;
  logic [N_DELAY-1:0] r_tagPipe;
  logic [N_DELAY:0] w_tagShift;
  logic [SW-1:0]    w_inflight;
  logic [SW-1:0]    w_credit;
  logic [CW-1:0]    w_fifoCnt;
  logic [AW-1:0]    w_nextAddr;
  logic             w_accept;
  logic             w_issue;
  logic             w_lastIssue;
  logic             w_push;
  logic             w_pop;
  logic             w_lastBeat;
  logic             w_full;
  logic             w_empty;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      w_inflight = w_inflight + SW'(r_tagPipe[i]);
    end
  end

  // Credit check deliberately ignores a same-cycle pop so it stays conservative.
  assign w_credit    = SW'(w_fifoCnt) + w_inflight;
  assign w_issue     = (r_state == RUN) && (r_rdCnt < r_numQ) &&
                       (w_credit < SW'(FIFO_DEPTH));
  assign w_lastIssue = w_issue && (r_rdCnt == r_numQ - (AW+1)'(1));
  assign w_tagShift  = {r_tagPipe, w_issue};
  assign w_push      = r_tagPipe[N_DELAY-1];
  assign w_accept    = (r_state == IDLE) && start;
  assign w_pop       = m_valid && m_ready;
  assign w_lastBeat  = w_pop && (r_outCnt == r_numQ - (AW+1)'(1));
  assign w_nextAddr  = r_baseQ + r_rdCnt[AW-1:0];
  assign addrb       = w_issue ? w_nextAddr : r_addrb;
  assign m_valid     = !w_empty;

  always_comb begin
    w_stateNext = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == FIN);
    enb         = (r_state == RUN) || (r_state == DRAIN);
    unique case (r_state)
      IDLE:    if (start) w_stateNext = (num_words == '0) ? FIN : RUN;
      RUN:     if (w_lastIssue) w_stateNext = DRAIN;
      DRAIN:   if (w_lastBeat) w_stateNext = FIN;
      FIN:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_baseQ   <= '0;
      r_numQ    <= '0;
      r_rdCnt   <= '0;
      r_outCnt  <= '0;
      r_addrb   <= '0;
      r_tagPipe <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_tagPipe <= w_tagShift[N_DELAY-1:0];
      if (w_issue) begin
        r_addrb <= w_nextAddr;
      end
      if (w_accept) begin
        r_baseQ  <= base_addr;
        r_numQ   <= num_words;
        r_rdCnt  <= '0;
        r_outCnt <= '0;
      end else begin
        if (w_issue) begin
          r_rdCnt <= r_rdCnt + (AW+1)'(1);
        end
        if (w_pop) begin
          r_outCnt <= r_outCnt + (AW+1)'(1);
        end
      end
    end
  end

  sync_fifo_fwft #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_pushData (dob),
    .i_pop      (w_pop),
    .o_popData  (m_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_fifoCnt)
  );

  pushNotFull: assert property (@(posedge clk) disable iff (!rstn) !(w_push && w_full));
  creditBound: assert property (@(posedge clk) disable iff (!rstn) w_credit <= SW'(FIFO_DEPTH));

endmodule

// File: tb/tb_dpram_rd_streamer.sv
// Runs two streamer instances side by side (read latency 1 and 3) against a
// shared RAM image and checks words, ordering, timing and control behaviour.
module tb_dpram_rd_streamer;

  typedef struct {
    logic [3:0] base;
    logic [4:0] num;
    bit         toggle;
    int         midStart;
    bit         gapFree;
    int         lat0;
    int         lat1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  num_words;
  logic        m_ready;
  logic [1:0]  busyV, doneV, enbV, validV;
  logic [7:0]  addrP;
  logic [63:0] dataP, dobP;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int startCyc;
  int firstEnb[2], firstValid[2], firstBeat[2], lastBeat[2];
  int doneCyc[2], busyLow[2], beats[2], nDone[2], nAddr[2];
  bit sawBusy[2], stallPrev[2];
  logic [31:0] stallData[2];
  logic [3:0]  addrLog[2][32];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] ram[16];
  logic [31:0] pipe1;
  logic [31:0] pipe3[3];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM read ports: the read pipeline only advances while enb is high.
  always @(posedge clk) if (enbV[0]) pipe1 <= ram[addrP[3:0]];
  always @(posedge clk) begin
    if (enbV[1]) begin
      pipe3[0] <= ram[addrP[7:4]];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end
  assign dobP = {pipe3[2], pipe1};

  dpram_rd_streamer #(.DW(32), .AW(4), .N_DELAY(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busyV[0]), .done(doneV[0]), .enb(enbV[0]), .addrb(addrP[3:0]), .dob(dobP[31:0]),
    .m_valid(validV[0]), .m_data(dataP[31:0]), .m_ready(m_ready));

  dpram_rd_streamer #(.DW(32), .AW(4), .N_DELAY(3), .FIFO_DEPTH(8)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busyV[1]), .done(doneV[1]), .enb(enbV[1]), .addrb(addrP[7:4]), .dob(dobP[63:32]),
    .m_valid(validV[1]), .m_data(dataP[63:32]), .m_ready(m_ready));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({busyV, doneV, enbV, validV}), 64'(0));
    checkOutput({tag, "_addr"}, 64'(addrP), 64'(0));
    checkOutput({tag, "_data"}, dataP, 64'(0));
  endtask

  task automatic clearLogs();
    for (int g = 0; g < 2; g++) begin
      firstEnb[g] = -1; firstValid[g] = -1; firstBeat[g] = -1; lastBeat[g] = -1;
      doneCyc[g] = -1; busyLow[g] = -1; beats[g] = 0; nDone[g] = 0; nAddr[g] = 0;
      sawBusy[g] = 1'b0; stallPrev[g] = 1'b0;
    end
  endtask

  // Called once per cycle on the falling edge: logs events and scores beats.
  task automatic sampleCycle();
    logic [31:0] expW;
    logic [31:0] got;
    logic [3:0]  a;
    bit          have;
    for (int g = 0; g < 2; g++) begin
      got = dataP[g*32 +: 32];
      a   = addrP[g*4 +: 4];
      if (enbV[g]) begin
        if (firstEnb[g] < 0) firstEnb[g] = cyc;
        if (nAddr[g] < 32 && (nAddr[g] == 0 || addrLog[g][nAddr[g]-1] != a)) begin
          addrLog[g][nAddr[g]] = a;
          nAddr[g]++;
        end
      end
      if (validV[g] && firstValid[g] < 0) firstValid[g] = cyc;
      if (stallPrev[g]) begin
        checkOutput($sformatf("stall_hold_g%0d", g), 64'({validV[g], got}), 64'({1'b1, stallData[g]}));
      end
      if (validV[g] && m_ready) begin
        have = 1'b0;
        expW = '0;
        if (g == 0 && q0.size() > 0) begin expW = q0.pop_front(); have = 1'b1; end
        if (g == 1 && q1.size() > 0) begin expW = q1.pop_front(); have = 1'b1; end
        if (have) begin
          checkOutput($sformatf("beat_data_g%0d", g), 64'(got), 64'(expW));
        end else begin
          nTests++;
          nFail++;
          $display("[TB] FAIL extra_beat_g%0d: got %0h, expected no beat", g, got);
        end
        beats[g]++;
        if (firstBeat[g] < 0) firstBeat[g] = cyc;
        lastBeat[g] = cyc;
      end
      stallPrev[g] = validV[g] && !m_ready;
      stallData[g] = got;
      if (doneV[g]) begin
        nDone[g]++;
        doneCyc[g] = cyc;
      end
      if (busyV[g]) sawBusy[g] = 1'b1;
      else if (sawBusy[g] && busyLow[g] < 0) busyLow[g] = cyc;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] base, input logic [4:0] num);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    num_words = num;
    m_ready = 1'b1;
    startCyc = cyc;
    clearLogs();
    for (int i = 0; i < int'(num); i++) begin
      logic [3:0] a;
      a = base + 4'(i);
      q0.push_back(32'h100 + 32'(a));
      q1.push_back(32'h100 + 32'(a));
    end
    @(negedge clk);
    sampleCycle();
  endtask

  task automatic tick(input logic rdy, input bit spur);
    @(posedge clk);
    #1;
    m_ready = rdy;
    start = spur;
    if (spur) begin
      base_addr = 4'd7;
      num_words = 5'd2;
    end
    @(negedge clk);
    sampleCycle();
  endtask

  task automatic runVector(input vec_t v, input int idx);
    bit finished;
    int mism;
    int expLat;
    logic [3:0] a;
    applyStimulus(v.base, v.num);
    finished = 1'b0;
    for (int k = 1; k < 400 && !finished; k++) begin
      tick(v.toggle ? 1'((k % 3) == 0) : 1'b1, k == v.midStart);
      finished = nDone[0] > 0 && nDone[1] > 0 && busyLow[0] >= 0 && busyLow[1] >= 0;
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checkOutput($sformatf("v%0d_complete", idx), 64'(finished), 64'(1));
    for (int g = 0; g < 2; g++) begin
      expLat = (g == 0) ? v.lat0 : v.lat1;
      checkOutput($sformatf("v%0d_g%0d_beats", idx, g), 64'(beats[g]), 64'(v.num));
      checkOutput($sformatf("v%0d_g%0d_missing", idx, g), 64'((g == 0) ? q0.size() : q1.size()), 64'(0));
      checkOutput($sformatf("v%0d_g%0d_ndone", idx, g), 64'(nDone[g]), 64'(1));
      checkOutput($sformatf("v%0d_g%0d_enb_delay", idx, g), 64'(firstEnb[g] - startCyc), 64'(1));
      checkOutput($sformatf("v%0d_g%0d_valid_lat", idx, g), 64'(firstValid[g] - firstEnb[g]), 64'(expLat));
      checkOutput($sformatf("v%0d_g%0d_done_delay", idx, g), 64'(doneCyc[g] - lastBeat[g]), 64'(1));
      checkOutput($sformatf("v%0d_g%0d_busy_drop", idx, g), 64'(busyLow[g] - doneCyc[g]), 64'(1));
      mism = 0;
      for (int i = 0; i < int'(v.num); i++) begin
        a = v.base + 4'(i);
        if (addrLog[g][i] != a) mism++;
      end
      checkOutput($sformatf("v%0d_g%0d_addr_count", idx, g), 64'(nAddr[g]), 64'(v.num));
      checkOutput($sformatf("v%0d_g%0d_addr_errs", idx, g), 64'(mism), 64'(0));
      if (v.gapFree) begin
        checkOutput($sformatf("v%0d_g%0d_gapless", idx, g), 64'(lastBeat[g] - firstBeat[g]), 64'(int'(v.num) - 1));
      end
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit reached;
    vec_t rv;
    vecs[0] = '{base: 4'd0,  num: 5'd8,  toggle: 1'b0, midStart: -1, gapFree: 1'b1, lat0: 2, lat1: 4};
    vecs[1] = '{base: 4'd0,  num: 5'd16, toggle: 1'b1, midStart: -1, gapFree: 1'b0, lat0: 2, lat1: 4};
    vecs[2] = '{base: 4'd14, num: 5'd4,  toggle: 1'b0, midStart: -1, gapFree: 1'b1, lat0: 2, lat1: 4};
    vecs[3] = '{base: 4'd0,  num: 5'd16, toggle: 1'b0, midStart: -1, gapFree: 1'b1, lat0: 2, lat1: 4};
    vecs[4] = '{base: 4'd2,  num: 5'd8,  toggle: 1'b0, midStart: 3,  gapFree: 1'b1, lat0: 2, lat1: 4};
    vecs[5] = '{base: 4'd9,  num: 5'd1,  toggle: 1'b0, midStart: -1, gapFree: 1'b1, lat0: 2, lat1: 4};
    vecs[6] = '{base: 4'd10, num: 5'd12, toggle: 1'b1, midStart: -1, gapFree: 1'b0, lat0: 2, lat1: 4};

    for (int i = 0; i < 16; i++) ram[i] = 32'h100 + 32'(i);
    rstn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    m_ready = 1'b0;
    clearLogs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkQuiet("reset_state");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checkQuiet("idle_after_reset");

    for (int v = 0; v < 7; v++) begin
      runVector(vecs[v], v);
    end

    // Zero-length request: straight to the done pulse, no RAM reads.
    applyStimulus(4'd5, 5'd0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("zero_g%0d_ndone", g), 64'(nDone[g]), 64'(1));
      checkOutput($sformatf("zero_g%0d_done_delay", g), 64'(doneCyc[g] - startCyc), 64'(1));
      checkOutput($sformatf("zero_g%0d_no_enb", g), 64'(firstEnb[g]), 64'(-1));
      checkOutput($sformatf("zero_g%0d_beats", g), 64'(beats[g]), 64'(0));
    end

    // Abort mid-stream with an asynchronous reset, then restart cleanly.
    applyStimulus(4'd0, 5'd16);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      tick(1'b1, 1'b0);
      reached = (beats[0] >= 5);
    end
    checkOutput("abort_reached_5_beats", 64'(reached), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    checkQuiet("async_abort");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rv = '{base: 4'd3, num: 5'd5, toggle: 1'b0, midStart: -1, gapFree: 1'b1, lat0: 2, lat1: 4};
    runVector(rv, 7);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
